// File: rtl/uart_rx_if.sv
// Host-side view of the UART receiver: FIFO head and pop strobe, error-flag clear, and status.
interface uart_rx_if;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    modport master (output rd_en, clr_err,
                    input  rx_data, rx_valid, rx_busy, frame_err, overrun);
    modport slave  (input  rd_en, clr_err,
                    output rx_data, rx_valid, rx_busy, frame_err, overrun);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. It samples each bit at mid-bit and feeds a small FIFO.
// Framing and overrun errors are held in sticky flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 68,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;

    logic          rx_m, rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          at_last, push, stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign at_last  = (cnt == CNT_LAST);
    assign push     = (state == STOP) && at_last && rx_s;
    assign stop_bad = (state == STOP) && at_last && !rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (at_last) begin
                        cnt       <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (at_last) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : BRK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // A held-low line waits here rather than decoding as a stream of 0x00 frames.
                BRK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_busy = (state != IDLE);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nx;
    logic [AW:0]   count, count_nx;
    logic          full, do_pop, do_push;
    logic [7:0]    head_nx;

    assign full     = (count == CNT_FULL);
    assign do_pop   = bus.rd_en && (count != '0);
    assign do_push  = push && (!full || do_pop);
    assign rd_ptr_nx = do_pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_nx = count;
        if (do_push && !do_pop) count_nx = count + (AW+1)'(1);
        if (!do_push && do_pop) count_nx = count - (AW+1)'(1);
    end

    // The registered head must see a byte being written into the slot that becomes the head.
    always_comb begin
        head_nx = mem[rd_ptr_nx];
        if (do_push && (wr_ptr == rd_ptr_nx)) head_nx = shift_reg;
        if (count_nx == '0) head_nx = 8'h00;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            bus.rx_data   <= 8'h00;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            rd_ptr      <= rd_ptr_nx;
            count       <= count_nx;
            bus.rx_data <= head_nx;
            if (do_push) wr_ptr <= wr_ptr + AW'(1);

            if (stop_bad)          bus.frame_err <= 1'b1;
            else if (bus.clr_err)  bus.frame_err <= 1'b0;

            if (push && full && !do_pop) bus.overrun <= 1'b1;
            else if (bus.clr_err)        bus.overrun <= 1'b0;
        end
    end

    assign bus.rx_valid = (count != '0);
endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized checks of uart_rx.
// The reference is a byte queue plus two flag bits, updated per whole frame.
module tb_uart_rx;
    localparam int C  = 68;
    localparam int D  = 4;
    localparam int SE = (C - 1) / 2 + 9 * C + 4;  // edges from start-bit drive to stop sample

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    byte unsigned q[$];
    bit m_ovr = 1'b0;
    bit m_ferr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".valid"}, {31'd0, bus.rx_valid}, {31'd0, q.size() != 0});
        chk({tag, ".data"}, {24'd0, bus.rx_data}, (q.size() != 0) ? {24'd0, q[0]} : 32'd0);
        chk({tag, ".frame_err"}, {31'd0, bus.frame_err}, {31'd0, m_ferr});
        chk({tag, ".overrun"}, {31'd0, bus.overrun}, {31'd0, m_ovr});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_push(input byte unsigned b);
        if (q.size() < D) q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    // One full frame; optionally pops exactly in the stop-sample cycle, or checks rx_valid latency.
    task automatic send(input byte unsigned b, input bit pop_at_stop, input bit lat);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        rx = fr[0];
        for (int k = 1; k <= 10 * C; k++) begin
            @(posedge clk);
            #1;
            if (k % C == 0 && k < 10 * C) rx = fr[k / C];
            if (pop_at_stop && k == SE - 1) begin
                if (q.size() != 0) chk("pop_head", {24'd0, bus.rx_data}, {24'd0, q[0]});
                bus.rd_en = 1'b1;
            end
            if (pop_at_stop && k == SE) bus.rd_en = 1'b0;
            if (lat && k == SE - 1) chk("lat_before", {31'd0, bus.rx_valid}, 32'd0);
            if (lat && k == SE) begin
                chk("lat_valid", {31'd0, bus.rx_valid}, 32'd1);
                chk("lat_data", {24'd0, bus.rx_data}, {24'd0, b});
            end
        end
        if (pop_at_stop && q.size() != 0) void'(q.pop_front());
        model_push(b);
    endtask

    task automatic pop_chk(input string tag);
        chk_state(tag);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic clr();
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        m_ovr = 1'b0;
        m_ferr = 1'b0;
    endtask

    initial begin
        logic [9:0] fr;
        byte unsigned rb;
        bit rp;
        bus.rd_en = 1'b0;
        bus.clr_err = 1'b0;
        tick(3);
        chk_state("reset");
        chk("reset.busy", {31'd0, bus.rx_busy}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        send(8'hA5, 1'b0, 1'b1);
        chk_state("a5");
        pop_chk("a5_pop");
        chk_state("a5_empty");

        send(8'h01, 1'b0, 1'b0);
        send(8'h80, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        chk_state("four");
        for (int i = 0; i < 4; i++) pop_chk("four_pop");
        chk_state("four_empty");

        for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1'b0, 1'b0);
        chk_state("ovr");
        for (int i = 0; i < 4; i++) pop_chk("ovr_pop");
        clr();
        chk_state("ovr_clr");

        for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b0, 1'b0);
        send(8'h14, 1'b1, 1'b0);
        chk_state("full_pop_push");
        for (int i = 0; i < 4; i++) pop_chk("fpp_pop");
        pop_chk("pop_empty");
        chk_state("pop_empty_after");

        rx = 1'b0;
        tick(10);
        chk("glitch.busy_during", {31'd0, bus.rx_busy}, 32'd1);
        tick(10);
        rx = 1'b1;
        tick(40);
        chk("glitch.busy_after", {31'd0, bus.rx_busy}, 32'd0);
        chk_state("glitch");

        rx = 1'b0;
        tick(12 * C);
        m_ferr = 1'b1;
        chk("break.busy_held", {31'd0, bus.rx_busy}, 32'd1);
        chk_state("break");
        rx = 1'b1;
        tick(4);
        chk("break.busy_after", {31'd0, bus.rx_busy}, 32'd0);
        chk_state("break_release");
        clr();
        send(8'h3C, 1'b0, 1'b0);
        chk_state("after_break");
        pop_chk("3c_pop");

        send(8'h77, 1'b0, 1'b0);
        chk_state("preload");
        fr = {1'b1, 8'h55, 1'b0};
        rx = fr[0];
        for (int k = 1; k <= 4 * C + C / 2; k++) begin
            @(posedge clk);
            #1;
            if (k % C == 0) rx = fr[k / C];
        end
        rst_n = 1'b0;
        #1;
        q.delete();
        chk_state("midreset");
        chk("midreset.busy", {31'd0, bus.rx_busy}, 32'd0);
        rx = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(10 * C);
        chk_state("midreset_quiet");
        send(8'h55, 1'b0, 1'b0);
        chk_state("after_reset_55");
        pop_chk("55_pop");

        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom);
            rp = 1'($urandom_range(0, 1));
            send(rb, rp, 1'b0);
            chk_state("rand");
            if ($urandom_range(0, 2) == 0) pop_chk("rand_pop");
        end
        for (int i = 0; i < D + 1; i++) pop_chk("drain");
        chk_state("drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
